// File: rtl/boot_uart_transmitter.sv
// Boot-link UART transmitter: 8N1 (or 8E1 with BOOT_UART_TX_PARITY_EN), LSB first.
// Latency: start bit appears on o_tx the cycle after accept; frame = 10 (11) bit times.
// Backpressure: o_byte_ready only in IDLE or last STOP cycle; unaccepted bytes are not queued.
// Optional feature macro: BOOT_UART_TX_PARITY_EN (even parity bit after bit7).
module boot_uart_transmitter #(
    parameter int clk_frequency = 50_000_000,
    parameter int baud_rate     = 115_200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_byte_valid,
    input  logic [7:0] i_byte_data,
    output logic       o_byte_ready,
    output logic       o_busy,
    output logic       o_tx
);

    // Bit period in clocks; must come out >= 2 for the reload/advance scheme to work.
    localparam int CYCLES_PER_BIT = clk_frequency / baud_rate;
    localparam int CNT_W          = $clog2(CYCLES_PER_BIT + 1);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CYCLES_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic             r_tx;
`ifdef BOOT_UART_TX_PARITY_EN
    logic             r_parity;
`endif

    logic w_sym_end;
    logic w_accept;

    // Down-counter at 1 marks the last cycle of the current symbol.
    assign w_sym_end    = (r_cnt == CNT_ONE);
    // Ready in the final STOP cycle lets the next start bit follow with no idle gap.
    assign o_byte_ready = (r_state == S_IDLE) | ((r_state == S_STOP) & w_sym_end);
    assign w_accept     = i_byte_valid & o_byte_ready;
    assign o_busy       = (r_state != S_IDLE);
    assign o_tx         = r_tx;

    // Frame sequencer: symbol timing, data shifting and registered line drive.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
`ifdef BOOT_UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_accept) begin
                        r_state   <= S_START;
                        r_shift   <= i_byte_data;
                        r_cnt     <= CNT_LOAD;
                        r_bit_cnt <= '0;
                        r_tx      <= 1'b0;
`ifdef BOOT_UART_TX_PARITY_EN
                        r_parity  <= ^i_byte_data;
`endif
                    end
                end

                S_START: begin
                    if (w_sym_end) begin
                        r_state <= S_DATA;
                        r_cnt   <= CNT_LOAD;
                        r_tx    <= r_shift[0];
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end

                S_DATA: begin
                    if (w_sym_end) begin
                        r_cnt <= CNT_LOAD;
                        if (r_bit_cnt == 3'd7) begin
                            r_bit_cnt <= '0;
`ifdef BOOT_UART_TX_PARITY_EN
                            r_state   <= S_PARITY;
                            r_tx      <= r_parity;
`else
                            r_state   <= S_STOP;
                            r_tx      <= 1'b1;
`endif
                        end else begin
                            // Shift so the next data bit is always at bit 0.
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end

                S_PARITY: begin
                    if (w_sym_end) begin
                        r_state <= S_STOP;
                        r_cnt   <= CNT_LOAD;
                        r_tx    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end

                S_STOP: begin
                    if (w_sym_end) begin
                        if (w_accept) begin
                            // Chain straight into the next frame's start bit.
                            r_state   <= S_START;
                            r_shift   <= i_byte_data;
                            r_cnt     <= CNT_LOAD;
                            r_bit_cnt <= '0;
                            r_tx      <= 1'b0;
`ifdef BOOT_UART_TX_PARITY_EN
                            r_parity  <= ^i_byte_data;
`endif
                        end else begin
                            r_state <= S_IDLE;
                            r_cnt   <= '0;
                            r_tx    <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule
